// File: rtl/mc_option_scheduler.sv
// mc_option_scheduler: sequences one option at a time through the ExpMu/ExpSigma
// table generators and the MC cores. The table RAM bank is ping-ponged so that
// generation of option N+1 overlaps core evaluation of option N.
// Ports: CLK/RST (async high); iOptValid/oOptReady/iMu/iS/iSigma option intake;
//   oMu/oS/oSigma/oGenStart/iGenDoneMu/iGenDoneSigma generator side;
//   oSwitch bank select; oCoreStart/iCoreDone core side;
//   oResultValid/oResultTag/oRunCycles completion report; oBusy activity.
`timescale 1ns/1ps
module mc_option_scheduler #(
   parameter int CoreN = 2,
   parameter int TagW  = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             iOptValid,
   output logic             oOptReady,
   input  logic [17:0]      iMu,
   input  logic [17:0]      iS,
   input  logic [17:0]      iSigma,
   output logic [17:0]      oMu,
   output logic [17:0]      oS,
   output logic [17:0]      oSigma,
   output logic             oGenStart,
   input  logic             iGenDoneMu,
   input  logic             iGenDoneSigma,
   output logic             oSwitch,
   output logic             oCoreStart,
   input  logic [CoreN-1:0] iCoreDone,
   output logic             oResultValid,
   output logic [TagW-1:0]  oResultTag,
   output logic [15:0]      oRunCycles,
   output logic             oBusy
);

   typedef enum logic [1:0] {G_IDLE, G_RUN, G_READY} genState_t;
   typedef enum logic {C_IDLE, C_RUN} coreState_t;

   genState_t  genState, genNext;
   coreState_t coreState, coreNext;

   logic [TagW-1:0]  nextTag, genTag, coreTag;
   logic             muDone, sigDone;
   logic [CoreN-1:0] coreFlags;
   logic [15:0]      runCnt;

   logic             accept, handoff, coreFinish;
   logic             muSet, sigSet;
   logic [CoreN-1:0] coreSet;
   logic [15:0]      cntInc;

   assign oOptReady = (genState == G_IDLE);
   assign oBusy     = (genState != G_IDLE) || (coreState != C_IDLE);

   always_comb begin
      genNext    = genState;
      coreNext   = coreState;
      accept     = 1'b0;
      handoff    = 1'b0;
      coreFinish = 1'b0;
      // done pulses sampled on this edge count towards completion
      muSet      = muDone | iGenDoneMu;
      sigSet     = sigDone | iGenDoneSigma;
      coreSet    = coreFlags | iCoreDone;
      cntInc     = (runCnt == 16'hFFFF) ? runCnt : runCnt + 16'd1;

      unique case (genState)
         G_IDLE: begin
            if (iOptValid) begin
               accept  = 1'b1;
               genNext = G_RUN;
            end
         end
         G_RUN: begin
            if (muSet && sigSet) genNext = G_READY;
         end
         G_READY: begin
            if (coreState == C_IDLE) begin
               handoff = 1'b1;
               genNext = G_IDLE;
            end
         end
         default: genNext = G_IDLE;
      endcase

      unique case (coreState)
         C_IDLE: begin
            if (handoff) coreNext = C_RUN;
         end
         C_RUN: begin
            if (&coreSet) begin
               coreFinish = 1'b1;
               coreNext   = C_IDLE;
            end
         end
         default: coreNext = C_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         genState     <= G_IDLE;
         coreState    <= C_IDLE;
         oMu          <= '0;
         oS           <= '0;
         oSigma       <= '0;
         oGenStart    <= 1'b0;
         oSwitch      <= 1'b0;
         oCoreStart   <= 1'b0;
         oResultValid <= 1'b0;
         oResultTag   <= '0;
         oRunCycles   <= '0;
         nextTag      <= '0;
         genTag       <= '0;
         coreTag      <= '0;
         muDone       <= 1'b0;
         sigDone      <= 1'b0;
         coreFlags    <= '0;
         runCnt       <= '0;
      end else begin
         genState     <= genNext;
         coreState    <= coreNext;
         oGenStart    <= accept;
         oCoreStart   <= handoff;
         oResultValid <= coreFinish;

         if (accept) begin
            oMu     <= iMu;
            oS      <= iS;
            oSigma  <= iSigma;
            genTag  <= nextTag;
            nextTag <= nextTag + 1'b1;
            muDone  <= 1'b0;
            sigDone <= 1'b0;
         end else if (genState == G_RUN) begin
            muDone  <= muSet;
            sigDone <= sigSet;
         end

         if (handoff) begin
            oSwitch   <= ~oSwitch;
            coreTag   <= genTag;
            runCnt    <= '0;
            coreFlags <= '0;
         end else if (coreState == C_RUN) begin
            runCnt <= cntInc;
            if (coreFinish) begin
               coreFlags  <= '0;
               oResultTag <= coreTag;
               oRunCycles <= cntInc;
            end else begin
               coreFlags <= coreSet;
            end
         end
      end
   end

endmodule

// File: tb/tb_mc_option_scheduler.sv
// tb_mc_option_scheduler: directed self-checking bench for mc_option_scheduler.
// Ports: none; drives the DUT and prints a single TB_RESULT summary line.
`timescale 1ns/1ps
module tb_mc_option_scheduler;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        iOptValid = 1'b0;
   logic        oOptReady;
   logic [17:0] iMu = '0, iS = '0, iSigma = '0;
   logic [17:0] oMu, oS, oSigma;
   logic        oGenStart;
   logic        iGenDoneMu = 1'b0, iGenDoneSigma = 1'b0;
   logic        oSwitch, oCoreStart;
   logic [1:0]  iCoreDone = 2'b00;
   logic        oResultValid;
   logic [7:0]  oResultTag;
   logic [15:0] oRunCycles;
   logic        oBusy;

   int checks = 0;
   int failures = 0;
   int genPulses = 0, corePulses = 0, resPulses = 0, clash = 0;
   int g0, c0, r0;

   mc_option_scheduler #(.CoreN(2), .TagW(8)) dut (
      .CLK(CLK), .RST(RST),
      .iOptValid(iOptValid), .oOptReady(oOptReady),
      .iMu(iMu), .iS(iS), .iSigma(iSigma),
      .oMu(oMu), .oS(oS), .oSigma(oSigma),
      .oGenStart(oGenStart),
      .iGenDoneMu(iGenDoneMu), .iGenDoneSigma(iGenDoneSigma),
      .oSwitch(oSwitch), .oCoreStart(oCoreStart),
      .iCoreDone(iCoreDone),
      .oResultValid(oResultValid), .oResultTag(oResultTag),
      .oRunCycles(oRunCycles), .oBusy(oBusy)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (!RST) begin
         if (oGenStart) genPulses++;
         if (oCoreStart) corePulses++;
         if (oResultValid) resPulses++;
         if (oCoreStart && oResultValid) clash++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic offer(input logic [17:0] mu, input logic [17:0] s, input logic [17:0] sg);
      iMu = mu; iS = s; iSigma = sg; iOptValid = 1'b1;
      step(1);
      iOptValid = 1'b0;
   endtask

   task automatic runOption(input int i);
      offer(18'(i), 18'(i + 1), 18'(i + 2));
      iGenDoneMu = 1'b1; iGenDoneSigma = 1'b1;
      step(1);
      iGenDoneMu = 1'b0; iGenDoneSigma = 1'b0;
      step(1);
      chk("wrapSwitch", 32'(oSwitch), 32'((i % 2) == 0));
      iCoreDone = 2'b11;
      step(1);
      iCoreDone = 2'b00;
      chk("wrapTag", {23'd0, oResultValid, oResultTag}, {23'd0, 1'b1, 8'(i % 256)});
   endtask

   initial begin
      step(2);
      RST = 1'b0;
      step(1);
      chk("rstReady", 32'(oOptReady), 1);
      chk("rstBusy", 32'(oBusy), 0);
      chk("rstSwitch", 32'(oSwitch), 0);
      chk("rstTag", 32'(oResultTag), 0);
      chk("rstCycles", 32'(oRunCycles), 0);
      chk("rstGenStart", 32'(oGenStart), 0);
      chk("rstMu", 32'(oMu), 0);

      // single option: accept at edge 0
      g0 = genPulses; c0 = corePulses; r0 = resPulses;
      offer(18'h01000, 18'h0A000, 18'h02000);
      chk("t1GenStart", 32'(oGenStart), 1);
      chk("t1Ready", 32'(oOptReady), 0);
      chk("t1S", 32'(oS), 32'h0A000);
      chk("t1Sigma", 32'(oSigma), 32'h02000);
      step(1);
      chk("t1GenStartLow", 32'(oGenStart), 0);
      step(168);
      iGenDoneMu = 1'b1; step(1); iGenDoneMu = 1'b0;
      step(24);
      iGenDoneSigma = 1'b1; step(1); iGenDoneSigma = 1'b0;
      chk("t1NoCoreYet", 32'(oCoreStart), 0);
      step(1);
      chk("t1CoreStart", 32'(oCoreStart), 1);
      chk("t1Switch", 32'(oSwitch), 1);
      chk("t1ReadyBack", 32'(oOptReady), 1);
      step(1);
      chk("t1CoreStartLow", 32'(oCoreStart), 0);
      step(1002);
      iCoreDone = 2'b11; step(1); iCoreDone = 2'b00;
      chk("t1Valid", 32'(oResultValid), 1);
      chk("t1Tag", 32'(oResultTag), 0);
      chk("t1Cycles", 32'(oRunCycles), 1004);
      step(1);
      chk("t1ValidLow", 32'(oResultValid), 0);
      chk("t1Idle", 32'(oBusy), 0);
      chk("t1Pulses", 32'((genPulses - g0) * 100 + (corePulses - c0) * 10 + (resPulses - r0)), 111);

      // overlap: option B generated while A runs
      offer(18'h00100, 18'h04000, 18'h00200);
      iGenDoneMu = 1'b1; iGenDoneSigma = 1'b1; step(1);
      iGenDoneMu = 1'b0; iGenDoneSigma = 1'b0;
      step(1);
      chk("ovCoreStartA", 32'(oCoreStart), 1);
      chk("ovSwitchA", 32'(oSwitch), 0);
      chk("ovReadyAtHandoff", 32'(oOptReady), 1);
      offer(18'h00300, 18'h05000, 18'h00400);
      chk("ovGenStartB", 32'(oGenStart), 1);
      chk("ovMuB", 32'(oMu), 32'h00300);
      iGenDoneMu = 1'b1; iGenDoneSigma = 1'b1; step(1);
      iGenDoneMu = 1'b0; iGenDoneSigma = 1'b0;
      step(1);
      chk("ovWaitCore", 32'(oCoreStart), 0);
      chk("ovReadyHeld", 32'(oOptReady), 0);
      step(5);
      iCoreDone = 2'b11; step(1); iCoreDone = 2'b00;
      chk("ovValidA", 32'(oResultValid), 1);
      chk("ovTagA", 32'(oResultTag), 1);
      chk("ovCyclesA", 32'(oRunCycles), 9);
      chk("ovNoClash", 32'(oCoreStart), 0);
      step(1);
      chk("ovCoreStartB", 32'(oCoreStart), 1);
      chk("ovSwitchB", 32'(oSwitch), 1);
      iCoreDone = 2'b11; step(1); iCoreDone = 2'b00;
      chk("ovTagB", {23'd0, oResultValid, oResultTag}, {23'd0, 1'b1, 8'd2});
      chk("ovCyclesB", 32'(oRunCycles), 1);
      step(1);

      // done order and duplicates
      g0 = genPulses; c0 = corePulses; r0 = resPulses;
      offer(18'h00010, 18'h01000, 18'h00020);
      iGenDoneSigma = 1'b1; step(1); iGenDoneSigma = 1'b0;
      step(3);
      chk("doSigmaOnly", 32'(oOptReady), 0);
      chk("doNoCore", 32'(oCoreStart), 0);
      iGenDoneMu = 1'b1; step(1);
      step(1);
      iGenDoneMu = 1'b0;
      chk("doHandoff", 32'(oCoreStart), 1);
      chk("doSwitch", 32'(oSwitch), 0);
      iCoreDone = 2'b10; step(1); iCoreDone = 2'b00;
      step(4);
      chk("doWaitCore0", 32'(oResultValid), 0);
      iCoreDone = 2'b01; step(1); iCoreDone = 2'b00;
      chk("doTag", {23'd0, oResultValid, oResultTag}, {23'd0, 1'b1, 8'd3});
      chk("doCycles", 32'(oRunCycles), 6);
      step(2);
      chk("doPulses", 32'((genPulses - g0) * 100 + (corePulses - c0) * 10 + (resPulses - r0)), 111);

      // spurious pulses while idle
      iGenDoneMu = 1'b1; iCoreDone = 2'b01; step(1);
      iGenDoneMu = 1'b0; iCoreDone = 2'b00;
      chk("spBusy", 32'(oBusy), 0);
      chk("spReady", 32'(oOptReady), 1);
      chk("spValid", 32'(oResultValid), 0);
      offer(18'h00001, 18'h00002, 18'h00003);
      iGenDoneSigma = 1'b1; step(1); iGenDoneSigma = 1'b0;
      step(3);
      chk("spNeedMu", 32'(oOptReady), 0);
      iGenDoneMu = 1'b1; step(1); iGenDoneMu = 1'b0;
      step(1);
      chk("spHandoff", {30'd0, oCoreStart, oSwitch}, 32'b11);
      iCoreDone = 2'b10; step(1); iCoreDone = 2'b00;
      step(2);
      chk("spNeedCore0", 32'(oResultValid), 0);
      iCoreDone = 2'b01; step(1); iCoreDone = 2'b00;
      chk("spTag", {23'd0, oResultValid, oResultTag}, {23'd0, 1'b1, 8'd4});
      step(1);

      // reset with core running and generator running
      offer(18'h00aaa, 18'h00bbb, 18'h00ccc);
      iGenDoneMu = 1'b1; iGenDoneSigma = 1'b1; step(1);
      iGenDoneMu = 1'b0; iGenDoneSigma = 1'b0;
      step(1);
      offer(18'h00ddd, 18'h00eee, 18'h00fff);
      step(3);
      #2 RST = 1'b1;
      #1;
      chk("arReady", 32'(oOptReady), 1);
      chk("arBusy", 32'(oBusy), 0);
      chk("arSwitch", 32'(oSwitch), 0);
      chk("arMu", 32'(oMu), 0);
      chk("arTag", 32'(oResultTag), 0);
      chk("arCycles", 32'(oRunCycles), 0);
      chk("arStarts", {30'd0, oGenStart, oCoreStart}, 0);
      @(posedge CLK); #1;
      RST = 1'b0;

      // tag wrap across 257 options
      for (int i = 0; i < 257; i++) runOption(i);
      step(2);
      chk("noClash", 32'(clash), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mc_option_scheduler.md
# mc_option_scheduler

Sequencing controller for the Monte Carlo risk engine. It accepts one option's parameters at a time (mu, S, sigma) through a valid/ready handshake and starts the ExpMu/ExpSigma table generators. It collects their done pulses and ping-pongs the table RAM bank between generators and MC cores. It starts the cores and reports completion of each option with a sequence tag. Generation of option N+1 overlaps core evaluation of option N.

## Interface
Parameters:
- CoreN, 2, number of MC cores whose done pulses are collected
- TagW, 8, width of option sequence tag

Ports:
- CLK  in  1  system clock, all state on rising edge
- RST  in  1  asynchronous, active-high reset
- iOptValid  in  1  option parameters valid
- oOptReady  out  1  scheduler can accept an option
- iMu  in  18  drift, 18 fract
- iS  in  18  spot, 4 int / 14 fract
- iSigma  in  18  volatility, 18 fract
- oMu, oS, oSigma  out  18 each  latched parameters driving the generators; stable from accept until next accept
- oGenStart  out  1  one-cycle start pulse to all ExpMu/ExpSigma generators
- iGenDoneMu  in  1  done pulse from ExpMu generator 0
- iGenDoneSigma  in  1  done pulse from ExpSigma generator 0
- oSwitch  out  1  bank select; generators write bank oSwitch, cores read bank ~oSwitch
- oCoreStart  out  1  one-cycle start pulse to all cores
- iCoreDone  in  CoreN  per-core done pulses
- oResultValid  out  1  one-cycle pulse: all cores finished current option
- oResultTag  out  TagW  tag of the option whose results are valid
- oRunCycles  out  16  edges spent in core run for that option, saturating at 65535
- oBusy  out  1  any FSM not idle

## Operation
- Generator FSM: G_IDLE, G_RUN, G_READY.
  - G_IDLE: oOptReady=1. On an edge with iOptValid=1, latch iMu/iS/iSigma into oMu/oS/oSigma. Assign genTag=nextTag, nextTag+1 (wraps 2^TagW-1 to 0). Clear done flags, assert oGenStart next cycle, go to G_RUN.
  - G_RUN: set sticky muDone on iGenDoneMu and sigDone on iGenDoneSigma. When both are set, including pulses sampled on this edge, go to G_READY. Done pulses in G_IDLE or G_READY are ignored.
  - G_READY: wait for handoff.
- Handoff is taken on the first edge where gen=G_READY and core=C_IDLE. On that edge: toggle oSwitch, assert oCoreStart for the following cycle, set coreTag=genTag, clear the cycle counter, gen goes to G_IDLE and core goes to C_RUN.
- Core FSM: C_IDLE, C_RUN.
  - C_RUN: set per-core sticky flags from iCoreDone and increment the cycle counter (saturating) each edge.
  - When all CoreN flags are set, including this edge: oResultValid=1 for the next cycle, oResultTag=coreTag, oRunCycles=counter value including this edge, clear flags, go to C_IDLE.
  - iCoreDone in C_IDLE is ignored.
- oResultTag and oRunCycles hold until the next result.
- oOptReady is combinational: (gen==G_IDLE). Handshake completes on any edge with iOptValid&&oOptReady. iOptValid does not need to be held after accept.
- oBusy = (gen!=G_IDLE) || (core!=C_IDLE).

## Timing
- Reset values: oOptReady=1, oMu/oS/oSigma=0, oGenStart=0, oSwitch=0, oCoreStart=0, oResultValid=0, oResultTag=0, oRunCycles=0, oBusy=0, nextTag=0, all flags cleared, both FSMs idle.
- Accept at edge k: oGenStart high from k to k+1, and oOptReady low after k.
- Last generator done sampled at edge n, core idle: handoff at edge n+1, oCoreStart high from n+1 to n+2.
- Core busy when generation finishes: handoff at edge m+1, where m is the edge that samples the last iCoreDone. oResultValid (from m) and oCoreStart (from m+1) are never high in the same cycle.
- After handoff at edge h, oOptReady=1 from h, so the next option can be accepted at h+1. Accept and handoff cannot occur on the same edge.
- Duplicate done pulses are idempotent.
- RST asserted mid-operation returns all state to reset values immediately (asynchronous) and drops in-flight options. Release is synchronous to the next edge.

## Test plan
- Single option: iMu=0x01000, iS=0x0A000, iSigma=0x02000 accepted at edge 0; iGenDoneMu at 170, iGenDoneSigma at 195; iCoreDone=2'b11 at 1200 -> oGenStart at cycle 1, oCoreStart at 196, oSwitch=1 after 196, oResultValid at 1201 with tag 0 and oRunCycles=1004.
- Overlap: second option accepted at edge 197, its generation completes before the cores finish -> its handoff occurs on the edge after the first oResultValid edge, oSwitch returns to 0, result tag 1.
- Done order/duplicates: iGenDoneSigma before iGenDoneMu, an extra iGenDoneMu pulse, and core1 done 5 cycles before core0 -> handoff only after both generator flags are set, result only after core0, no extra pulses.
- Spurious pulses while idle (iGenDoneMu, iCoreDone=2'b01) -> no state change; next option still requires fresh pulses.
- Tag wrap: 257 back-to-back options -> tags 0..255, then 0.
- Reset during C_RUN and G_RUN -> all outputs at reset values immediately, oOptReady=1, next option gets tag 0, oSwitch starts at 0.
